pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central pipeline sequencer for the RT core's five-stage FE/DE/EX/MEM/WB pipeline. It merges the decode load-use stall from the forwarding logic, taken-branch flushes, data-memory wait handshakes and multi-cycle vector-reduce occupancy into per-stage enables, a flush and bubble-insert controls. It also owns run/halt sequencing and a stall-cycle performance counter.

## Interface
- REDUCE_LAT, 4, total EX cycles of a vector-reduce op (≥2)
- CNT_W, 32, width of stall performance counter
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution, from IDLE or HALTED
- DE_stall  in  1  load-use/reduce-use stall from decode forwarding logic
- EX_branch_taken  in  1  branch in EX resolved taken
- EX_reduce_start  in  1  EX holds a vector-reduce op in its first cycle
- MEM_req  in  1  MEM-stage instruction accesses data memory
- MEM_ready  in  1  data memory completes access this cycle
- WB_halt  in  1  halt instruction in WB
- FE_en, DE_en, EX_en, MEM_en, WB_en  out  1 each  stage register load enables
- FE_DE_flush  out  1  clear FE/DE register to NOP
- DE_EX_bubble  out  1  load NOP into DE/EX register
- EX_MEM_bubble  out  1  load NOP into EX/MEM register
- done  out  1  core halted
- stall_cycles  out  CNT_W  saturating count of cycles with FE_en=0 in RUN/MEM_WAIT/REDUCE_WAIT

## Operation
- States: IDLE, RUN, MEM_WAIT, REDUCE_WAIT, HALTED. Reset: IDLE, reduce counter 0, stall_cycles 0.
- IDLE: all outputs 0; start → RUN. stall_cycles cleared when start is accepted.
- RUN, first matching rule wins:
  1. WB_halt: all enables 0 → HALTED.
  2. MEM_req && !MEM_ready: all enables 0 → MEM_WAIT.
  3. EX_reduce_start: FE/DE/EX_en 0; MEM/WB_en 1; EX_MEM_bubble 1; counter ← REDUCE_LAT−1 → REDUCE_WAIT.
  4. EX_branch_taken: all enables 1, FE_DE_flush 1, DE_EX_bubble 1. DE_stall ignored.
  5. DE_stall: FE/DE_en 0, EX/MEM/WB_en 1, DE_EX_bubble 1.
  6. Otherwise all enables 1, no flush/bubble.
- MEM_WAIT: !MEM_ready → all enables 0, stay. MEM_ready → outputs and next state as RUN rules 3–6 (rule 1 also applies); rule 2 is satisfied.
- REDUCE_WAIT: FE/DE/EX_en 0, MEM/WB_en 1, EX_MEM_bubble 1, counter decrements. Counter==1 → RUN next cycle.
  - Total EX freeze is exactly REDUCE_LAT cycles, including the start cycle.
  - WB_halt here → HALTED.
  - MEM_req is ignored because MEM holds a bubble.
- HALTED: all enables 0, done 1; start → RUN, done clears.
- Simultaneous MEM_req and EX_reduce_start: memory wins. EX stays frozen, so EX_reduce_start is re-presented when memory completes.
- Bubble/flush outputs are meaningful only when the matching stage enable is 1.
- stall_cycles saturates at all-ones.

## Timing
- State, counter and stall_cycles are registered. All stage controls are combinational from state plus same-cycle inputs, with zero-cycle response, because decode stalls must take effect in the cycle they are raised.
- done is a pure function of state: rises the cycle after WB_halt is seen.
- Async rst mid-operation: all outputs 0 immediately, state IDLE; start required to resume.
- REDUCE_LAT=2: one REDUCE_WAIT cycle.
- Counter width is $clog2(REDUCE_LAT).

## Structure
- Shared package rt_pipe_pkg: state enum pipe_state_t, stage-enable struct type.
- No sub-module. Stall counter and reduce counter stay inline.

## Test plan
- Load-use: RUN, DE_stall=1 for 1 cycle → FE_en=DE_en=0, DE_EX_bubble=1, EX/MEM/WB_en=1; stall_cycles=1.
- Branch + DE_stall same cycle → FE_DE_flush=1, DE_EX_bubble=1, all enables 1; stall_cycles unchanged.
- Memory wait: MEM_req=1, MEM_ready low 3 cycles then high → 3 cycles all enables 0, 4th cycle all enables 1, state RUN; stall_cycles=3.
- Reduce with REDUCE_LAT=4: EX_reduce_start pulse → FE/DE/EX_en low exactly 4 cycles, EX_MEM_bubble high 4 cycles, RUN on 5th.
- MEM_req stalled + EX_reduce_start together → MEM_WAIT first; reduce sequence after MEM_ready.
- Halt/restart/reset:
  - WB_halt → done=1 next cycle, enables 0.
  - start → RUN, done=0.
  - rst asserted mid-REDUCE_WAIT → IDLE, counter 0, outputs 0 without a clock edge.

Source files
------------

// File: rtl/rt_pipe_pkg.sv
//==============================================================================
// Module : rt_pipe_pkg
// Shared types for the RT core pipeline sequencer: FSM states, stage enables.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package rt_pipe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RUN         = 3'd1,
        ST_MEM_WAIT    = 3'd2,
        ST_REDUCE_WAIT = 3'd3,
        ST_HALTED      = 3'd4
    } pipe_state_t;

    typedef struct packed {
        logic fe;
        logic de;
        logic ex;
        logic mem;
        logic wb;
    } stage_en_t;

    localparam stage_en_t C_EN_NONE  = 5'b00000;
    localparam stage_en_t C_EN_ALL   = 5'b11111;
    localparam stage_en_t C_EN_BACK2 = 5'b00011;
    localparam stage_en_t C_EN_BACK3 = 5'b00111;

endpackage

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
//==============================================================================
// Module : pipeline_stall_ctrl
// Five-stage pipeline sequencer: stage enables, flush/bubble, run/halt, stall count.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipeline_stall_ctrl
    import rt_pipe_pkg::*;
#(
    parameter int REDUCE_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             DE_stall,
    input  logic             EX_branch_taken,
    input  logic             EX_reduce_start,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    input  logic             WB_halt,
    output logic             FE_en,
    output logic             DE_en,
    output logic             EX_en,
    output logic             MEM_en,
    output logic             WB_en,
    output logic             FE_DE_flush,
    output logic             DE_EX_bubble,
    output logic             EX_MEM_bubble,
    output logic             done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int              RC_W          = $clog2(REDUCE_LAT);
    localparam logic [RC_W-1:0] C_REDUCE_INIT = RC_W'(REDUCE_LAT - 1);
    localparam logic [RC_W-1:0] C_RC_ONE      = RC_W'(1);

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic [RC_W-1:0]  r_red_cnt;
    logic [RC_W-1:0]  w_red_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    stage_en_t        w_en;
    logic             w_flush;
    logic             w_de_bubble;
    logic             w_ex_bubble;
    logic             w_count_stall;

    always_comb begin
        w_next_state   = r_state;
        w_red_cnt_next = r_red_cnt;
        w_en           = C_EN_NONE;
        w_flush        = 1'b0;
        w_de_bubble    = 1'b0;
        w_ex_bubble    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                // MEM_WAIT with MEM_ready resumes through the normal RUN priority.
                if (r_state == ST_MEM_WAIT && !MEM_ready) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (WB_halt) begin
                    w_next_state = ST_HALTED;
                end else if (r_state == ST_RUN && MEM_req && !MEM_ready) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (EX_reduce_start) begin
                    w_en           = C_EN_BACK2;
                    w_ex_bubble    = 1'b1;
                    w_red_cnt_next = C_REDUCE_INIT;
                    w_next_state   = ST_REDUCE_WAIT;
                end else if (EX_branch_taken) begin
                    w_en         = C_EN_ALL;
                    w_flush      = 1'b1;
                    w_de_bubble  = 1'b1;
                    w_next_state = ST_RUN;
                end else if (DE_stall) begin
                    w_en         = C_EN_BACK3;
                    w_de_bubble  = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_en         = C_EN_ALL;
                    w_next_state = ST_RUN;
                end
            end
            ST_REDUCE_WAIT: begin
                if (WB_halt) begin
                    w_red_cnt_next = '0;
                    w_next_state   = ST_HALTED;
                end else begin
                    w_en           = C_EN_BACK2;
                    w_ex_bubble    = 1'b1;
                    w_red_cnt_next = r_red_cnt - C_RC_ONE;
                    if (r_red_cnt == C_RC_ONE) w_next_state = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (start) w_next_state = ST_RUN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_count_stall = !w_en.fe && (r_state == ST_RUN || r_state == ST_MEM_WAIT ||
                                        r_state == ST_REDUCE_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_red_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_red_cnt <= w_red_cnt_next;
            if (r_state == ST_IDLE && start) begin
                r_stall_cnt <= '0;
            end else if (w_count_stall && r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign FE_en         = w_en.fe;
    assign DE_en         = w_en.de;
    assign EX_en         = w_en.ex;
    assign MEM_en        = w_en.mem;
    assign WB_en         = w_en.wb;
    assign FE_DE_flush   = w_flush;
    assign DE_EX_bubble  = w_de_bubble;
    assign EX_MEM_bubble = w_ex_bubble;
    assign done          = (r_state == ST_HALTED);
    assign stall_cycles  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
//==============================================================================
// Module : tb_pipeline_stall_ctrl
// Directed and random checks of pipeline_stall_ctrl against a pipeline-hold model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;

    localparam int REDUCE_LAT = 4;
    localparam int CNT_W      = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_MEMW = 2, M_RED = 3, M_HALT = 4;

    logic clk = 1'b0;
    logic rst, start, DE_stall, EX_branch_taken, EX_reduce_start;
    logic MEM_req, MEM_ready, WB_halt;
    logic FE_en, DE_en, EX_en, MEM_en, WB_en;
    logic FE_DE_flush, DE_EX_bubble, EX_MEM_bubble, done;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int m_mode = M_IDLE;
    int m_left = 0;
    int m_stall = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.REDUCE_LAT(REDUCE_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .DE_stall(DE_stall),
        .EX_branch_taken(EX_branch_taken), .EX_reduce_start(EX_reduce_start),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready), .WB_halt(WB_halt),
        .FE_en(FE_en), .DE_en(DE_en), .EX_en(EX_en), .MEM_en(MEM_en), .WB_en(WB_en),
        .FE_DE_flush(FE_DE_flush), .DE_EX_bubble(DE_EX_bubble),
        .EX_MEM_bubble(EX_MEM_bubble), .done(done), .stall_cycles(stall_cycles)
    );

    function automatic logic [8:0] observed();
        return {FE_en, DE_en, EX_en, MEM_en, WB_en, FE_DE_flush, DE_EX_bubble,
                EX_MEM_bubble, done};
    endfunction

    // Model: 'hold' = number of leading stages frozen this cycle (0 = all run, 5 = none).
    task automatic step(input logic s, input logic st, input logic br, input logic rs,
                        input logic rq, input logic rd, input logic hl);
        int         hold  = 5;
        int         nmode = m_mode;
        int         nleft = m_left;
        logic       fl = 1'b0, db = 1'b0, eb = 1'b0;
        logic [8:0] exp;
        start = s; DE_stall = st; EX_branch_taken = br; EX_reduce_start = rs;
        MEM_req = rq; MEM_ready = rd; WB_halt = hl;
        case (m_mode)
            M_IDLE, M_HALT: if (s) nmode = M_RUN;
            M_RUN, M_MEMW: begin
                if (m_mode == M_MEMW && !rd) nmode = M_MEMW;
                else if (hl) nmode = M_HALT;
                else if (m_mode == M_RUN && rq && !rd) nmode = M_MEMW;
                else if (rs) begin
                    hold = 3; eb = 1'b1; nleft = REDUCE_LAT - 1; nmode = M_RED;
                end else begin
                    nmode = M_RUN;
                    if (br) begin hold = 0; fl = 1'b1; db = 1'b1; end
                    else if (st) begin hold = 2; db = 1'b1; end
                    else hold = 0;
                end
            end
            M_RED: begin
                if (hl) nmode = M_HALT;
                else begin
                    hold = 3; eb = 1'b1; nleft = m_left - 1;
                    if (m_left == 1) nmode = M_RUN;
                end
            end
            default: nmode = M_IDLE;
        endcase
        for (int i = 0; i < 5; i++) exp[8-i] = (i >= hold);
        exp[3:0] = {fl, db, eb, (m_mode == M_HALT)};
        #4;
        checks++;
        assert (observed() === exp) else begin
            errors++;
            $error("FAIL ctrl cyc=%0d observed=%b expected=%b", cyc, observed(), exp);
        end
        checks++;
        assert (stall_cycles === CNT_W'(m_stall)) else begin
            errors++;
            $error("FAIL stall_cycles cyc=%0d observed=%0d expected=%0d", cyc,
                   stall_cycles, m_stall);
        end
        @(posedge clk);
        if (m_mode == M_IDLE && s) m_stall = 0;
        else if ((m_mode == M_RUN || m_mode == M_MEMW || m_mode == M_RED) && hold > 0 &&
                 m_stall < (1 << CNT_W) - 1) m_stall++;
        m_mode = nmode;
        m_left = nleft;
        cyc++;
        #1;
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; DE_stall = 1'b0; EX_branch_taken = 1'b0;
        EX_reduce_start = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0; WB_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (observed() === 9'b0 && stall_cycles === '0) else begin
            errors++;
            $error("FAIL reset observed=%b/%0d expected=0/0", observed(), stall_cycles);
        end
        rst = 1'b0;
        idle_cycle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);       // start
        idle_cycle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);       // load-use
        idle_cycle();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       // branch beats stall
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // memory wait
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);       // reduce
        repeat (REDUCE_LAT) idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);       // memory beats reduce
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (REDUCE_LAT) idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);       // halt
        repeat (2) idle_cycle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);       // restart
        idle_cycle();

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset in the middle of a reduce sequence.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        assert (observed() === 9'b0 && stall_cycles === '0) else begin
            errors++;
            $error("FAIL async_rst observed=%b/%0d expected=0/0", observed(), stall_cycles);
        end
        m_mode = M_IDLE; m_left = 0; m_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) idle_cycle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (REDUCE_LAT + 1) idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
